// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl -- prescaled step sequencer driving a 4-bit XNOR LFSR and an
// 8-bit display shift register.
//
// A run is requested with start; every (div+1) clk cycles the sequencer
// issues a step, which advances the LFSR and shifts the display register.
// A run ends after nsteps steps (done pulse), or runs forever when
// nsteps == 0. stop pauses a run and, from pause, aborts it.
//
// Optional feature macro: LFSR_SEED_EN (adds seed / seed_load inputs).
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-high reset
//   start      in   run / resume request (level)
//   stop       in   pause / abort request (level), wins over start
//   div        in   [DIV_W] step period minus 1, in clk cycles
//   nsteps     in   [CNT_W] steps per run, 0 = free-run
//   seed       in   [4] LFSR seed value          (LFSR_SEED_EN only)
//   seed_load  in   load seed while idle          (LFSR_SEED_EN only)
//   busy       out  high in RUN and PAUSE
//   done       out  one-cycle pulse on run completion
//   step       out  high in the cycle before each advance edge
//   lfsr_q     out  [4] LFSR state
//   disp       out  [8] display shift register
module lfsr_seq_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nsteps,
`ifdef LFSR_SEED_EN
  input  logic [3:0]       seed,
  input  logic             seed_load,
`endif
  output logic             busy,
  output logic             done,
  output logic             step,
  output logic [3:0]       lfsr_q,
  output logic [7:0]       disp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [3:0]       lfsr_d;
  logic [7:0]       disp_q,  disp_d;
  logic             step_c;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      lfsr_q  <= 4'b0000;
      disp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      lfsr_q  <= lfsr_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    lfsr_d  = lfsr_q;
    disp_d  = disp_q;
    step_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          presc_d = '0;
          rem_d   = nsteps;
        end
`ifdef LFSR_SEED_EN
        // The all-ones lockup state is never loaded; it maps to zero.
        if (seed_load) begin
          lfsr_d = (seed == 4'b1111) ? 4'b0000 : seed;
          disp_d = 8'h00;
        end
`endif
      end

      S_RUN: begin
        if (stop) begin
          // Pause holds prescaler and remaining count; no step this cycle.
          state_d = S_PAUSE;
        end else if (presc_q == div) begin
          step_c  = 1'b1;
          presc_d = '0;
          // remaining == 0 marks a free-running sequence: never counts down.
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end else begin
          // If div drops below the current count, this wraps via all-ones.
          presc_d = presc_q + 1'b1;
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step_c) begin
      lfsr_d = {lfsr_q[0], ~(lfsr_q[3] ^ lfsr_q[0]), lfsr_q[2], lfsr_q[1]};
      disp_d = {lfsr_q[2], disp_q[7:1]};
    end
  end

  assign step = step_c;
  assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done = (state_q == S_DONE);
  assign disp = disp_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed testbench for lfsr_seq_ctrl. Each scenario is a task with its
// own inline comparisons against hand-derived expected values.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [15:0] div = 16'd0;
  logic [7:0] nsteps = 8'd0;
`ifdef LFSR_SEED_EN
  logic [3:0] seed = 4'b0000;
  logic       seed_load = 1'b0;
`endif
  logic       busy, done, step;
  logic [3:0] lfsr_q;
  logic [7:0] disp;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  lfsr_seq_ctrl #(.DIV_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .div       (div),
    .nsteps    (nsteps),
`ifdef LFSR_SEED_EN
    .seed      (seed),
    .seed_load (seed_load),
`endif
    .busy      (busy),
    .done      (done),
    .step      (step),
    .lfsr_q    (lfsr_q),
    .disp      (disp)
  );

  always #5 clk = ~clk;

  // Counts cycles in which done was high.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #3;
    tests_run++;
    if ({busy, done, step, lfsr_q, disp} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b step=%b lfsr=%b disp=%h, want all 0",
               busy, done, step, lfsr_q, disp);
    end
    tick();
    clr = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || lfsr_q !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b lfsr=%b, want 0/0000", busy, lfsr_q);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_run();
    logic [3:0] exp_seq [4];
    int d0;
    exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0110;
    exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1011;
    do_clr();
    d0 = done_cnt;
    div = 16'd0; nsteps = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || step !== 1'b1 || lfsr_q !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_entry: busy=%b step=%b lfsr=%b, want 1/1/0000", busy, step, lfsr_q);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (lfsr_q !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL basic_lfsr[%0d]: got %b want %b", i, lfsr_q, exp_seq[i]);
      end
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || disp !== 8'hE0) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b busy=%b disp=%h, want 1/0/e0", done, busy, disp);
    end
    tick();
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || (done_cnt - d0) !== 1) begin
      tests_failed++;
      $display("FAIL basic_after: done=%b busy=%b pulses=%0d, want 0/0/1", done, busy, done_cnt - d0);
    end
    $display("[TB] test_basic_run done");
  endtask

  task automatic test_div3();
    logic exp_step;
    logic exp_done;
    do_clr();
    div = 16'd3; nsteps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_step = (k == 4) || (k == 8);
      exp_done = (k == 9);
      tests_run++;
      if (step !== exp_step || done !== exp_done) begin
        tests_failed++;
        $display("FAIL div3_cycle[%0d]: step=%b done=%b, want %b/%b", k, step, done, exp_step, exp_done);
      end
      if (k == 4 || k == 5) begin
        tests_run++;
        if (lfsr_q !== ((k == 4) ? 4'b0000 : 4'b0100)) begin
          tests_failed++;
          $display("FAIL div3_first_adv[%0d]: lfsr=%b", k, lfsr_q);
        end
      end
      tick();
    end
    tests_run++;
    if (lfsr_q !== 4'b0110 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL div3_end: lfsr=%b busy=%b, want 0110/0", lfsr_q, busy);
    end
    $display("[TB] test_div3 done");
  endtask

  task automatic test_freerun_pause();
    int d0;
    do_clr();
    d0 = done_cnt;
    div = 16'd0; nsteps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (lfsr_q !== 4'b0010 || disp !== 8'h9B || step !== 1'b1) begin
      tests_failed++;
      $display("FAIL free_10steps: lfsr=%b disp=%h step=%b, want 0010/9b/1", lfsr_q, disp, step);
    end
    stop = 1'b1;
    #1;
    tests_run++;
    if (step !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_stop_masks_step: step=%b want 0", step);
    end
    tick();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (busy !== 1'b1 || step !== 1'b0 || lfsr_q !== 4'b0010 || disp !== 8'h9B) begin
      tests_failed++;
      $display("FAIL free_paused: busy=%b step=%b lfsr=%b disp=%h, want 1/0/0010/9b",
               busy, step, lfsr_q, disp);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (lfsr_q !== 4'b0010 || step !== 1'b1) begin
      tests_failed++;
      $display("FAIL free_resume: lfsr=%b step=%b, want 0010/1", lfsr_q, step);
    end
    tick();
    tests_run++;
    if (lfsr_q !== 4'b0101) begin
      tests_failed++;
      $display("FAIL free_resume_adv: lfsr=%b want 0101", lfsr_q);
    end
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || (done_cnt - d0) !== 0 || lfsr_q !== 4'b0101) begin
      tests_failed++;
      $display("FAIL free_abort: busy=%b pulses=%0d lfsr=%b, want 0/0/0101", busy, done_cnt - d0, lfsr_q);
    end
    $display("[TB] test_freerun_pause done");
  endtask

  task automatic test_start_stop_idle();
    do_clr();
    div = 16'd0; nsteps = 8'd3;
    start = 1'b1; stop = 1'b1;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0 || lfsr_q !== 4'b0000 || step !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_start_stop: busy=%b lfsr=%b step=%b, want 0/0000/0", busy, lfsr_q, step);
    end
    start = 1'b0; stop = 1'b0;
    tick();
    $display("[TB] test_start_stop_idle done");
  endtask

  task automatic test_clr_midrun();
    int d0;
    do_clr();
    d0 = done_cnt;
    div = 16'd0; nsteps = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    clr = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, step, lfsr_q, disp} !== 15'd0) begin
      tests_failed++;
      $display("FAIL clr_midrun: busy=%b done=%b step=%b lfsr=%b disp=%h, want all 0",
               busy, done, step, lfsr_q, disp);
    end
    tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (busy !== 1'b0 || (done_cnt - d0) !== 0 || lfsr_q !== 4'b0000) begin
      tests_failed++;
      $display("FAIL clr_no_resume: busy=%b pulses=%0d lfsr=%b, want 0/0/0000", busy, done_cnt - d0, lfsr_q);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_restart: busy=%b want 1", busy);
    end
    for (int i = 0; i < 8; i++) tick();
    $display("[TB] test_clr_midrun done");
  endtask

  task automatic test_back_to_back();
    do_clr();
    div = 16'd0; nsteps = 8'd1; start = 1'b1;
    tick();
    tick();
    tests_run++;
    if (done !== 1'b1 || lfsr_q !== 4'b0100) begin
      tests_failed++;
      $display("FAIL b2b_done1: done=%b lfsr=%b, want 1/0100", done, lfsr_q);
    end
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || step !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_rerun: busy=%b done=%b step=%b, want 1/0/1", busy, done, step);
    end
    start = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1 || lfsr_q !== 4'b0110) begin
      tests_failed++;
      $display("FAIL b2b_done2: done=%b lfsr=%b, want 1/0110", done, lfsr_q);
    end
    tick();
    $display("[TB] test_back_to_back done");
  endtask

`ifdef LFSR_SEED_EN
  task automatic test_seed();
    do_clr();
    seed = 4'b1111; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tests_run++;
    if (lfsr_q !== 4'b0000 || disp !== 8'h00) begin
      tests_failed++;
      $display("FAIL seed_lockup: lfsr=%b disp=%h, want 0000/00", lfsr_q, disp);
    end
    seed = 4'b0110; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    tests_run++;
    if (lfsr_q !== 4'b0110) begin
      tests_failed++;
      $display("FAIL seed_load: lfsr=%b want 0110", lfsr_q);
    end
    $display("[TB] test_seed done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_run();
    test_div3();
    test_freerun_pause();
    test_start_stop_idle();
    test_clr_midrun();
    test_back_to_back();
`ifdef LFSR_SEED_EN
    test_seed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
